// File: rtl/tone_pkg.sv
// Shared types and constants for the two-channel square-wave tone synthesizer.
package tone_pkg;

  typedef enum logic [1:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_t;

  localparam int               LEVEL_W   = 8;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 8'd255;
  localparam int               AMP_SHIFT = 4;
  localparam int               AMP_W     = 15;
  localparam int               SAMPLE_W  = 16;

endpackage

// File: rtl/tone_osc.sv
// One square-wave channel: half-period counter, phase bit and divider-change restart.
module tone_osc #(
  parameter int DIV_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  output logic             phase,
  output logic             active
);

  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic             silent;

  assign silent = (div < DIV_MIN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q  <= '0;
      cnt    <= '0;
      phase  <= 1'b0;
      active <= 1'b0;
    end else begin
      div_q  <= div;
      active <= !silent;
      if (silent) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (div != div_q) begin
        // new period starts here; phase carries over so the waveform stays continuous
        cnt <= '0;
      end else if (cnt == div_q - DIV_W'(1)) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/tone_synth.sv
// Stereo square-wave tone synthesizer with shared level/volume scaling.
// Define TONE_ENVELOPE_EN for the attack/sustain/release envelope; otherwise level is a plain gate.
module tone_synth
  import tone_pkg::*;
#(
  parameter int DIV_W    = 22,
  parameter int ENV_TICK = 65536,
  parameter int ATK_STEP = 8,
  parameter int REL_STEP = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       note_on,
  input  logic [DIV_W-1:0]           div_left,
  input  logic [DIV_W-1:0]           div_right,
  input  logic [2:0]                 volume,
  output logic signed [SAMPLE_W-1:0] audio_left,
  output logic signed [SAMPLE_W-1:0] audio_right,
  output logic                       env_busy
);

  if (ENV_TICK < 1 || ATK_STEP < 1 || REL_STEP < 1) begin : g_bad_param
    $error("tone_synth: ENV_TICK, ATK_STEP and REL_STEP must all be >= 1");
  end

  function automatic logic signed [SAMPLE_W-1:0] to_sample(input logic [AMP_W-1:0] amp,
                                                           input logic             ph,
                                                           input logic             act);
    logic signed [SAMPLE_W-1:0] mag;
    mag = signed'({1'b0, amp});
    if (!act) return '0;
    return ph ? mag : -mag;
  endfunction

  logic [LEVEL_W-1:0] level;
  logic               phase_l, phase_r;
  logic               active_l, active_r;

  tone_osc #(.DIV_W(DIV_W)) u_osc_left (
    .clk    (clk),
    .rst    (rst),
    .div    (div_left),
    .phase  (phase_l),
    .active (active_l)
  );

  tone_osc #(.DIV_W(DIV_W)) u_osc_right (
    .clk    (clk),
    .rst    (rst),
    .div    (div_right),
    .phase  (phase_r),
    .active (active_r)
  );

`ifdef TONE_ENVELOPE_EN
  localparam int PRE_W = (ENV_TICK > 1) ? $clog2(ENV_TICK) : 1;

  function automatic logic [LEVEL_W-1:0] level_up(input logic [LEVEL_W-1:0] lvl);
    int sum;
    sum = int'(lvl) + ATK_STEP;
    return (sum >= int'(LEVEL_MAX)) ? LEVEL_MAX : LEVEL_W'(sum);
  endfunction

  function automatic logic [LEVEL_W-1:0] level_down(input logic [LEVEL_W-1:0] lvl);
    int diff;
    diff = int'(lvl) - REL_STEP;
    return (diff <= 0) ? '0 : LEVEL_W'(diff);
  endfunction

  env_state_t         state;
  logic [PRE_W-1:0]   pre;
  logic               tick;
  logic [LEVEL_W-1:0] lvl_up, lvl_down;

  assign tick     = (pre == PRE_W'(ENV_TICK - 1));
  assign lvl_up   = level_up(level);
  assign lvl_down = level_down(level);
  assign env_busy = (state != ENV_IDLE);

  always_ff @(posedge clk) begin
    if (!rst || tick) pre <= '0;
    else              pre <= pre + PRE_W'(1);
  end

  // note_on transitions take priority over a same-cycle tick step
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ENV_IDLE;
      level <= '0;
    end else begin
      case (state)
        ENV_IDLE: begin
          level <= '0;
          if (note_on) state <= ENV_ATTACK;
        end
        ENV_ATTACK: begin
          if (!note_on) begin
            state <= ENV_RELEASE;
          end else if (tick) begin
            level <= lvl_up;
            if (lvl_up == LEVEL_MAX) state <= ENV_SUSTAIN;
          end
        end
        ENV_SUSTAIN: begin
          level <= LEVEL_MAX;
          if (!note_on) state <= ENV_RELEASE;
        end
        ENV_RELEASE: begin
          if (note_on) begin
            state <= ENV_ATTACK;
          end else if (tick) begin
            level <= lvl_down;
            if (lvl_down == '0) state <= ENV_IDLE;
          end
        end
        default: begin
          state <= ENV_IDLE;
          level <= '0;
        end
      endcase
    end
  end
`else
  assign level    = note_on ? LEVEL_MAX : '0;
  assign env_busy = note_on;
`endif

  // stage p0: amplitude = level * volume * 16 (max 28560, fits 15 bits)
  logic [LEVEL_W+2:0] lv_prod;
  logic [AMP_W-1:0]   amp_p0;

  assign lv_prod = {3'b000, level} * {{LEVEL_W{1'b0}}, volume};
  assign amp_p0  = {lv_prod, {AMP_SHIFT{1'b0}}};

  // stage p1: registered signed samples
  logic signed [SAMPLE_W-1:0] audio_l_p1, audio_r_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      audio_l_p1 <= '0;
      audio_r_p1 <= '0;
    end else begin
      audio_l_p1 <= to_sample(amp_p0, phase_l, active_l);
      audio_r_p1 <= to_sample(amp_p0, phase_r, active_r);
    end
  end

  assign audio_left  = audio_l_p1;
  assign audio_right = audio_r_p1;

endmodule
